bcd_to_ascii_serializer: RTL
============================

# bcd_to_ascii_serializer

Sequential stage that takes a packed BCD number (as produced by the binary-to-BCD encoder) over a valid/ready handshake and emits it as a stream of ASCII characters, one per accepted transfer, most significant digit first. Leading zeros are optionally suppressed and an optional terminator character ends each number. It sits between the BCD encoder and a byte-oriented sink such as a UART transmitter or a debug console FIFO.

## Interface
- WIDTH_BCD, 12, packed BCD input width; multiple of 4; NUMBER_DIGITS = WIDTH_BCD/4, at least 1
- SUPPRESS_LEADING_ZEROS, 1, 1 = skip leading zero digits; 0 = emit all digits
- APPEND_TERMINATOR, 1, 1 = emit TERMINATOR_CHARACTER after the last digit
- TERMINATOR_CHARACTER, 8'h0A, terminator byte
- clock  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- bcd_data  input  WIDTH_BCD  packed BCD; digit k at bits [4k+3:4k]; digit 0 is least significant
- bcd_valid  input  1  bcd_data is valid
- bcd_ready  output  1  block can accept a number
- ascii_data  output  8  current character
- ascii_valid  output  1  ascii_data is valid
- ascii_ready  input  1  sink accepts ascii_data
- busy  output  1  a number is being serialized

## Operation
- The states are IDLE, EMIT and TERMINATE.
- IDLE: bcd_ready=1, busy=0, ascii_valid=0. When bcd_valid=1 in IDLE, the block:
  - captures bcd_data into an internal register;
  - loads the digit index with the most significant digit to emit: the highest non-zero digit if SUPPRESS_LEADING_ZEROS=1, otherwise NUMBER_DIGITS-1;
  - when all digits are zero and suppression is on, loads index 0 so that a single '0' is emitted;
  - goes to EMIT.
- EMIT: ascii_valid=1, busy=1, bcd_ready=0. The digit-to-character mapping is:
  - digit d at the current index becomes 8'h30+d for d≤9;
  - d in 10..15 becomes 8'h3F ('?'); for suppression purposes such a digit counts as non-zero.
- EMIT transitions, on each ascii_valid & ascii_ready:
  - if index>0, decrement the index and stay in EMIT;
  - if index=0, go to TERMINATE when APPEND_TERMINATOR=1, otherwise to IDLE.
- TERMINATE: ascii_valid=1 and ascii_data=TERMINATOR_CHARACTER. On handshake, go to IDLE.
- Without a handshake, ascii_data and ascii_valid hold stable, as the AXI-style rule requires. ascii_valid never depends combinationally on ascii_ready.
- bcd_data is sampled only at acceptance. Input changes during serialization have no effect.
- Only leading zeros are suppressed. Interior and trailing zeros are always emitted; for example, 12'h102 produces '1','0','2'.
- Reset mid-operation: on the next edge the block returns to IDLE. Remaining characters are discarded and no terminator is sent.

## Timing
- Values after reset: bcd_ready=1, ascii_valid=0, ascii_data=8'h00, busy=0.
- ascii_data and ascii_valid are registered. bcd_ready and busy are decoded from the state register.
- Latency: input accepted at edge N; the first character is valid in the cycle after edge N.
- Throughput: one character per cycle while ascii_ready=1. A number producing C characters occupies C cycles in EMIT/TERMINATE.
- One idle bubble follows each number: the last handshake is at edge M, bcd_ready=1 after M, and the next acceptance is no earlier than edge M+1.
- The leading-zero priority search is combinational over NUMBER_DIGITS digits, evaluated at acceptance only.
- Simultaneous reset and bcd_valid: reset wins and nothing is captured.

## Test plan
- Defaults, with 12'h255 accepted and ascii_ready held at 1: the outputs are 8'h32, 8'h35, 8'h35, 8'h0A on four consecutive cycles. bcd_ready returns to 1 after the fourth character.
- Leading-zero suppression:
  - 12'h007 produces 8'h37, 8'h0A;
  - 12'h000 produces 8'h30, 8'h0A;
  - 12'h100 produces 8'h31, 8'h30, 8'h30, 8'h0A.
- SUPPRESS_LEADING_ZEROS=0, APPEND_TERMINATOR=0, 12'h007: the outputs are 8'h30, 8'h30, 8'h37 and no terminator. bcd_ready=1 after the third handshake.
- Backpressure, 12'h255 with ascii_ready driven 1,0,0,1,0,1,1: each character stays stable across the stall cycles and the sequence is unchanged. bcd_data is changed to 12'h999 mid-stream with no effect on the output.
- Invalid digit, 12'h0A3: the outputs are 8'h3F, 8'h33, 8'h0A.
- Reset mid-operation: assert reset after the first character of 12'h255 is accepted. After the reset edge, ascii_valid=0 and bcd_ready=1. A new 12'h042 then produces 8'h34, 8'h32, 8'h0A.

Source files
------------

// File: rtl/bcd_to_ascii_serializer.sv
// Serializes a packed BCD number into ASCII digit characters, most significant
// first, with optional leading-zero suppression and an optional terminator byte.
module bcd_to_ascii_serializer #(
  parameter int unsigned WIDTH_BCD              = 12,
  parameter bit          SUPPRESS_LEADING_ZEROS = 1'b1,
  parameter bit          APPEND_TERMINATOR      = 1'b1,
  parameter logic [7:0]  TERMINATOR_CHARACTER   = 8'h0A
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH_BCD-1:0] bcd_data,
  input  logic                 bcd_valid,
  output logic                 bcd_ready,
  output logic [7:0]           ascii_data,
  output logic                 ascii_valid,
  input  logic                 ascii_ready,
  output logic                 busy
);

  localparam int unsigned NUMBER_DIGITS = WIDTH_BCD / 4;
  localparam int unsigned IDX_W         = (NUMBER_DIGITS > 1) ? $clog2(NUMBER_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, EMIT, TERMINATE} state_t;

  state_t               state;
  state_t               next_state;
  logic [WIDTH_BCD-1:0] bcd_reg;
  logic [IDX_W-1:0]     digit_index;
  logic [IDX_W-1:0]     start_index;
  logic [IDX_W-1:0]     dec_index;
  logic                 handshake;
  logic                 last_digit;

  // Digit select by explicit compare so index codes beyond NUMBER_DIGITS-1 read as zero.
  function automatic logic [3:0] digit_at(input logic [WIDTH_BCD-1:0] v,
                                          input logic [IDX_W-1:0]     idx);
    logic [3:0] d;
    d = '0;
    for (int unsigned k = 0; k < NUMBER_DIGITS; k++) begin
      if (idx == IDX_W'(k)) d = v[4*k +: 4];
    end
    return d;
  endfunction

  function automatic logic [7:0] to_ascii(input logic [3:0] d);
    return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
  endfunction

  // Highest non-zero digit wins; an all-zero number falls back to index 0.
  always_comb begin
    start_index = '0;
    if (SUPPRESS_LEADING_ZEROS) begin
      for (int unsigned k = 0; k < NUMBER_DIGITS; k++) begin
        if (bcd_data[4*k +: 4] != 4'd0) start_index = IDX_W'(k);
      end
    end else begin
      start_index = IDX_W'(NUMBER_DIGITS - 1);
    end
  end

  assign dec_index  = digit_index - IDX_W'(1);
  assign handshake  = ascii_valid & ascii_ready;
  assign last_digit = (digit_index == '0);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (bcd_valid) next_state = EMIT;
      EMIT:      if (handshake && last_digit)
                   next_state = APPEND_TERMINATOR ? TERMINATE : IDLE;
      TERMINATE: if (handshake) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    bcd_ready = (state == IDLE);
    busy      = (state != IDLE);
  end

  // Character register is loaded one step ahead so ascii_data/ascii_valid are flop outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      bcd_reg     <= '0;
      digit_index <= '0;
      ascii_data  <= '0;
      ascii_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bcd_valid) begin
            bcd_reg     <= bcd_data;
            digit_index <= start_index;
            ascii_data  <= to_ascii(digit_at(bcd_data, start_index));
            ascii_valid <= 1'b1;
          end
        end
        EMIT: begin
          if (handshake) begin
            if (!last_digit) begin
              digit_index <= dec_index;
              ascii_data  <= to_ascii(digit_at(bcd_reg, dec_index));
            end else if (APPEND_TERMINATOR) begin
              ascii_data  <= TERMINATOR_CHARACTER;
            end else begin
              ascii_data  <= '0;
              ascii_valid <= 1'b0;
            end
          end
        end
        TERMINATE: begin
          if (handshake) begin
            ascii_data  <= '0;
            ascii_valid <= 1'b0;
          end
        end
        default: begin
          ascii_data  <= '0;
          ascii_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
